// File: rtl/uart_tx_32.sv
// rtl/uart_tx_32.sv - 32-bit word serializer as four back-to-back 8N1 UART bytes
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst    in   1   asynchronous reset, active high
//   start  in   1   launch a word when idle (ignored while busy)
//   data   in  32   word to send, captured on the accepting edge
//   tx     out  1   registered serial line, idles high
//   busy   out  1   high for the full 40-bit-time transfer
`timescale 1ns/1ps
module uart_tx_32 #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] data,
    output logic        tx,
    output logic        busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [31:0]      shift, shift_d;
    logic [1:0]       byte_idx, byte_idx_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_d;
    logic             tx_d, busy_d;
    logic             bit_done;

    assign bit_done = (baud_cnt == CNT_MAX);

    // State and datapath registers; tx/busy are registered so the line is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            shift    <= shift_d;
            byte_idx <= byte_idx_d;
            bit_idx  <= bit_idx_d;
            baud_cnt <= baud_cnt_d;
            tx       <= tx_d;
            busy     <= busy_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state;
        shift_d    = shift;
        byte_idx_d = byte_idx;
        bit_idx_d  = bit_idx;
        baud_cnt_d = baud_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d    = START;
                    shift_d    = data;
                    byte_idx_d = 2'd0;
                    baud_cnt_d = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d    = DATA;
                    bit_idx_d  = 3'd0;
                    baud_cnt_d = '0;
                end else begin
                    baud_cnt_d = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    // Shifting across byte boundaries leaves the next byte in shift[7:0].
                    shift_d    = shift >> 1;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    if (byte_idx != 2'd3) begin
                        byte_idx_d = byte_idx + 2'd1;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level for the coming cycle is decided from the state being entered,
    // so tx changes on the same edge as the state.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        case (state_d)
            IDLE:    begin tx_d = 1'b1; busy_d = 1'b0; end
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            STOP:    tx_d = 1'b1;
            default: begin tx_d = 1'b1; busy_d = 1'b0; end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_32.sv
// tb/tb_uart_tx_32.sv - self-checking bench for uart_tx_32
`timescale 1ns/1ps
module tb_uart_tx_32;

    localparam int CPB     = 4;
    localparam int DEF_CPB = 50_000_000 / 115_200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] data = '0;
    logic        tx, busy;
    logic        start2 = 1'b0;
    logic [31:0] data2 = '0;
    logic        tx2, busy2;

    int nchk  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    uart_tx_32 #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .tx(tx), .busy(busy)
    );

    uart_tx_32 dut_def (
        .clk(clk), .rst(rst), .start(start2), .data(data2), .tx(tx2), .busy(busy2)
    );

    // Reference: the word as 40 line bits (4 bytes, each 0 + LSB-first data + 1),
    // each bit lasting cpb cycles after the accepting edge.
    function automatic logic exp_tx(input logic [31:0] w, input int k, input int cpb);
        int bit_no, b, p;
        logic [31:0] tmp;
        bit_no = k / cpb;
        b      = bit_no / 10;
        p      = bit_no % 10;
        tmp    = w;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return tmp[b*8 + p - 1];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge just after the accepting edge; leaves at the negedge
    // after the edge that ends the last stop bit.
    task automatic check_frame(input logic [31:0] w, input int inj_at, input logic [31:0] inj_data);
        for (int k = 0; k < 40*CPB; k++) begin
            if (inj_at >= 0 && k == inj_at) begin
                start = 1'b1;
                data  = inj_data;
            end else if (inj_at >= 0 && k == inj_at + 1) begin
                start = 1'b0;
                data  = $urandom;
            end
            chk($sformatf("tx w=%08h k=%0d", w, k), {31'b0, tx}, {31'b0, exp_tx(w, k, CPB)});
            chk($sformatf("busy w=%08h k=%0d", w, k), {31'b0, busy}, 32'd1);
            @(negedge clk);
        end
        chk($sformatf("end tx w=%08h", w), {31'b0, tx}, 32'd1);
        chk($sformatf("end busy w=%08h", w), {31'b0, busy}, 32'd0);
    endtask

    task automatic launch(input logic [31:0] w);
        @(negedge clk);
        start = 1'b1;
        data  = w;
        @(negedge clk);
        start = 1'b0;
        data  = $urandom;
    endtask

    initial begin
        logic [31:0] w;

        // Reset state, including a start pulse while reset is held
        @(negedge clk);
        chk("rst tx", {31'b0, tx}, 32'd1);
        chk("rst busy", {31'b0, busy}, 32'd0);
        start = 1'b1;
        data  = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rst hold tx", {31'b0, tx}, 32'd1);
            chk("rst hold busy", {31'b0, busy}, 32'd0);
            @(negedge clk);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle tx", {31'b0, tx}, 32'd1);
            chk("idle busy", {31'b0, busy}, 32'd0);
        end

        // Single word
        launch(32'h12345678);
        check_frame(32'h12345678, -1, 32'h0);

        // Start while busy is ignored
        launch(32'hA5A5A5A5);
        check_frame(32'hA5A5A5A5, 50, 32'h0);

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1;
        data  = 32'h000000FF;
        @(negedge clk);
        data  = 32'hFFFFFF00;
        check_frame(32'h000000FF, -1, 32'h0);
        @(negedge clk);
        start = 1'b0;
        data  = $urandom;
        check_frame(32'hFFFFFF00, -1, 32'h0);

        // Random words with random ignored starts
        for (int n = 0; n < 6; n++) begin
            w = $urandom;
            launch(w);
            check_frame(w, int'($urandom_range(0, 150)), $urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Asynchronous reset mid-frame (byte 2)
        launch(32'hCAFEF00D);
        for (int k = 0; k < 2*10*CPB + 9; k++) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async rst tx", {31'b0, tx}, 32'd1);
        chk("async rst busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3*10*CPB; i++) begin
            @(negedge clk);
            chk("post rst tx", {31'b0, tx}, 32'd1);
            chk("post rst busy", {31'b0, busy}, 32'd0);
        end
        w = $urandom;
        launch(w);
        check_frame(w, -1, 32'h0);

        // Default baud instance
        w = 32'h5A3C96E1;
        @(negedge clk);
        start2 = 1'b1;
        data2  = w;
        @(negedge clk);
        start2 = 1'b0;
        data2  = '0;
        for (int k = 0; k < 40*DEF_CPB; k++) begin
            if (tx2 !== exp_tx(w, k, DEF_CPB) || busy2 !== 1'b1 || (k % DEF_CPB) == DEF_CPB/2) begin
                chk($sformatf("def tx k=%0d", k), {31'b0, tx2}, {31'b0, exp_tx(w, k, DEF_CPB)});
                chk($sformatf("def busy k=%0d", k), {31'b0, busy2}, 32'd1);
            end
            @(negedge clk);
        end
        chk("def end tx", {31'b0, tx2}, 32'd1);
        chk("def end busy", {31'b0, busy2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
